// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit
// 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        SCAN = 1'b0,
        DEAD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_L     = 7'b0001110;
    localparam logic [6:0] SEG_S     = 7'b1011011;
    localparam logic [6:0] SEG_J     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode select for a digit index.
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to 7-segment pattern, segments {a..g},
// active-high.
import seg_pkg::*;

module hex_to_seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Hex glyph lookup.
    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_nib)
            4'h0: o_seg = 7'b1111110;
            4'h1: o_seg = 7'b0110000;
            4'h2: o_seg = 7'b1101101;
            4'h3: o_seg = 7'b1111001;
            4'h4: o_seg = 7'b0110011;
            4'h5: o_seg = 7'b1011011;
            4'h6: o_seg = 7'b1011111;
            4'h7: o_seg = 7'b1110000;
            4'h8: o_seg = 7'b1111111;
            4'h9: o_seg = 7'b1111011;
            4'hA: o_seg = 7'b1110111;
            4'hB: o_seg = 7'b0011111;
            4'hC: o_seg = 7'b1001110;
            4'hD: o_seg = 7'b0111101;
            4'hE: o_seg = 7'b1001111;
            4'hF: o_seg = 7'b1000111;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment driver with
// frame-synchronous shadow register snapshot.
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] opcode,
    input  logic [3:0] pc_lo,
    input  logic [7:0] data,
    input  logic       load_req,
    output logic       load_ack,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int MAXC =
        (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST =
        CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam bit NO_DEAD = (DEAD_CYCLES == 0);

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;

    logic [1:0]    r_op;
    logic [3:0]    r_pc;
    logic [7:0]    r_data;

    logic          r_ack;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    state_t        w_state_nxt;
    logic [1:0]    w_idx_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_adv;
    logic          w_fb;
    logic          w_cap;

    logic [1:0]    w_op;
    logic [3:0]    w_pc;
    logic [7:0]    w_data;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [6:0]    w_letter;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;

    // Scan state, digit index and in-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DEAD;
            r_idx   <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: SCAN for DIGIT_CYCLES, then DEAD for
    // DEAD_CYCLES (skipped when zero), then next digit.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_adv       = 1'b0;
        unique case (r_state)
            SCAN: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (NO_DEAD) begin
                        w_adv     = 1'b1;
                        w_idx_nxt = r_idx + 2'd1;
                    end else begin
                        w_state_nxt = DEAD;
                    end
                end
            end
            DEAD: begin
                if (r_cnt == DEAD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_adv       = 1'b1;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = SCAN;
                end
            end
            default: begin
                w_state_nxt = DEAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_fb  = w_adv && (r_idx == 2'd3);
    assign w_cap = w_fb && load_req;

    // A capture at the frame boundary must already be
    // visible in the first digit-0 pattern registered
    // on the same edge.
    assign w_op   = w_cap ? opcode : r_op;
    assign w_pc   = w_cap ? pc_lo  : r_pc;
    assign w_data = w_cap ? data   : r_data;

    // Nibble and letter selection for the upcoming digit.
    always_comb begin
        w_nib    = w_data[3:0];
        w_letter = SEG_A;
        unique case (w_idx_nxt)
            2'd2:    w_nib = w_pc;
            2'd1:    w_nib = w_data[7:4];
            default: w_nib = w_data[3:0];
        endcase
        unique case (w_op)
            2'b01:   w_letter = SEG_L;
            2'b10:   w_letter = SEG_S;
            2'b11:   w_letter = SEG_J;
            default: w_letter = SEG_A;
        endcase
    end

    hex_to_seg u_hex (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // Output pattern for the next cycle; dark in DEAD or
    // when blanked.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_an_nxt  = AN_OFF;
        if (!blank && (w_state_nxt == SCAN)) begin
            w_an_nxt  = an_sel(w_idx_nxt);
            w_seg_nxt = (w_idx_nxt == 2'd3) ? w_letter : w_hex;
        end
    end

    // Shadow registers, ack pulse and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= '0;
            r_pc   <= '0;
            r_data <= '0;
            r_ack  <= 1'b0;
            r_seg  <= SEG_BLANK;
            r_an   <= AN_OFF;
        end else begin
            r_op   <= w_op;
            r_pc   <= w_pc;
            r_data <= w_data;
            r_ack  <= w_cap;
            r_seg  <= w_seg_nxt;
            r_an   <= w_an_nxt;
        end
    end

    assign load_ack = r_ack;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule
